uart_mem_bridge: RTL and testbench
==================================

Name: uart_mem_bridge

Overview:
- Parametrised successor to the fixed UART-loader/SRAM controller.
- Bridges the UART RX/TX byte streams and a core memory bus (SERV-style cs/we/ack) onto one single-port synchronous SRAM such as RAM32.
- Host byte commands write words, read words, and hold or release the core's reset.
- Host accesses are allowed while the core runs; the two requesters are arbitrated round-robin.

Parameters:
- ADDR_W, 5: word-address width of the memory port; host sends ABYTES = ceil(ADDR_W/8) address bytes.
- DATA_W, 32: word width, a multiple of 8; NBYTES = DATA_W/8 byte lanes.
- ACK_BYTE, 8'h06: reply on success.
- NAK_BYTE, 8'h15: reply on error.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid; a byte is taken when rx_valid & rx_ready
- rx_ready  out  1  bridge can take a byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held with tx_data stable until the transfer
- tx_ready  in  1  transmitter can take a byte; transfer when tx_valid & tx_ready
- core_rst  out  1  active-high reset to the core
- core_cs  in  1  core request; held until core_ack
- core_we  in  1  core write
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_wmask  in  NBYTES  core byte enables
- core_rdata  out  DATA_W  read data, valid with core_ack
- core_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_we  out  NBYTES  byte write enables (0 = read)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en

Behaviour:
- Reset values:
  - core_rst=1; all other outputs 0 (rx_ready, tx_valid, core_ack, mem_en, mem_we, mem_addr, mem_wdata, core_rdata, tx_data).
  - Host FSM goes to IDLE; a partially received command is discarded with no memory write.
- Host FSM states: IDLE, ADDR, DATA, [CSUM], MEM_REQ, MEM_WAIT, RESP.
- rx_ready=1 only in IDLE, ADDR, DATA and CSUM.
- Command bytes (received in IDLE):
  - 'W' (8'h57): ADDR takes ABYTES bytes, little-endian; address bits at or above ADDR_W are ignored. DATA takes NBYTES bytes, LSB first. MEM_REQ then writes with mem_we all-ones, and RESP sends ACK_BYTE.
  - 'R' (8'h52): ADDR as above, then MEM_REQ reads. In MEM_WAIT the word is latched from mem_rdata. RESP sends the NBYTES bytes LSB first, each held until its tx handshake.
  - 'G' (8'h47): core_rst=0 from the cycle after the byte is accepted; RESP sends ACK_BYTE.
  - 'H' (8'h48): core_rst=1 from the cycle after the byte is accepted; RESP sends ACK_BYTE. A core access already granted still completes and acks.
  - Any other byte: RESP sends NAK_BYTE, then the FSM returns to IDLE.
- After the last RESP byte transfers, the FSM returns to IDLE.
- Arbitration (evaluated every cycle):
  - Core request = core_cs & ~core_rst & ~core_ack & no core access in flight.
  - Host request = FSM in MEM_REQ.
  - If only one requests, it is granted.
  - If both request, the one not granted most recently wins. The last-grant flag resets to "host".
  - The loser's request is held; the grant is issued combinationally onto the mem_* outputs, registered in the SRAM.
- Core access timing:
  - Grant in cycle N: mem_en=1, mem_we = core_we ? core_wmask : 0.
  - Cycle N+1: core_ack=1 and core_rdata=mem_rdata (write data is don't-care).
  - Core is never granted in its ack cycle, so the maximum core rate is 1 access per 2 cycles.
- Host access timing: grant in cycle N moves MEM_REQ to MEM_WAIT; N+1 latches the data and moves to RESP.
- Host wait is bounded: at most 2 cycles of core contention per host access.
- mem_* outputs are 0 in cycles with no grant.

Optional Feature:
- Macro: UART_MEM_BRIDGE_CHKSUM_EN.
- When defined:
  - 'W' expects one extra byte in state CSUM: the XOR of all address and data bytes.
  - On mismatch: no mem_en, reply NAK_BYTE.
  - 'R' appends the XOR of the NBYTES data bytes after the data.
- When undefined: no CSUM state and no extra bytes.

Test Plan:
- Write: after reset, check core_rst=1. Send 57,03,78,56,34,12 → one mem_en cycle with mem_addr=3, mem_we=F, mem_wdata=32'h12345678; tx byte 06.
- Read: send 52,03 → mem_en with mem_we=0, addr=3; tx 78,56,34,12 in order, with tx_ready toggled randomly and each byte held stable until its handshake.
- Control and bad opcode:
  - Send 99 → tx 15, FSM back in IDLE, no mem_en.
  - Send 47 → tx 06, core_rst=0.
  - Send 48 → core_rst=1.
- Contention: core_cs held for reads of addr 3 while the host sends 52,03 → grants alternate, core_ack every second cycle with core_rdata=12345678, and the host read completes within 2 cycles of entering MEM_REQ.
- Reset mid-write: send 57,03,AA, then pulse reset for 1 cycle → no mem_en; core_rst=1; a following 52,03 returns the previous contents.
- With UART_MEM_BRIDGE_CHKSUM_EN defined:
  - Send 57,03,78,56,34,12,00 (bad checksum) → tx 15, no write.
  - Send 57,03,78,56,34,12,0B → write, tx 06.

Source files
------------

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge
//
// Shares one single-port synchronous SRAM between a UART host and a core
// memory bus (cs/we/ack). The host speaks a small byte protocol:
//   'W' addr[ABYTES] data[NBYTES]  -> write word, reply ACK_BYTE
//   'R' addr[ABYTES]               -> reply with the word, LSB first
//   'G'                            -> release core reset, reply ACK_BYTE
//   'H'                            -> hold core in reset, reply ACK_BYTE
//   anything else                  -> reply NAK_BYTE
// Multi-byte fields are little-endian. Host and core requests are arbitrated
// round-robin every cycle; the winning request drives mem_* combinationally.
//
// Optional feature, macro UART_MEM_BRIDGE_CHKSUM_EN:
//   'W' carries a trailing XOR of all address and data bytes (mismatch means
//   no write and a NAK_BYTE reply); 'R' replies with a trailing XOR of the
//   data bytes.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   rx_data/valid/ready     byte stream from the UART receiver
//   tx_data/valid/ready     byte stream to the UART transmitter
//   core_rst                active-high reset for the core
//   core_cs/we/addr/wdata/wmask, core_rdata/ack   core memory bus
//   mem_en/we/addr/wdata, mem_rdata               SRAM port (1-cycle read)

module uart_mem_bridge #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 32,
    parameter logic [7:0]  ACK_BYTE = 8'h06,
    parameter logic [7:0]  NAK_BYTE = 8'h15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                core_rst,
    input  logic                core_cs,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_wmask,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_ack,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int ABYTES = (ADDR_W + 7) / 8;
    localparam int NBYTES = DATA_W / 8;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
    localparam int RD_LEN = NBYTES + 1;
`else
    localparam int RD_LEN = NBYTES;
`endif
    localparam int CNT_MAX = (ABYTES > RD_LEN) ? ABYTES : RD_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef UART_MEM_BRIDGE_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2, S_CSUM = 3'd3,
        S_MEM_REQ = 3'd4, S_MEM_WAIT = 3'd5, S_RESP = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd2,
        S_MEM_REQ = 3'd4, S_MEM_WAIT = 3'd5, S_RESP = 3'd6
    } state_t;
`endif

    // cmd_q also selects what RESP sends: ACK for W/G/H, NAK, or read data.
    typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ACK, CMD_NAK} cmd_t;

    state_t              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                core_rst_q, core_rst_d;
    logic                core_ack_q, core_ack_d;
    logic                last_core_q, last_core_d;   // 1: core won the last grant
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          rd_csum;
`endif

    logic                rx_fire, tx_fire;
    logic                host_req, core_req, grant_host, grant_core;
    logic [CNT_W-1:0]    resp_last;
    logic [7:0]          tx_byte;
    logic [7:0]          rd_byte [NBYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign rd_byte[gi] = data_q[gi*8 +: 8];
        end
    endgenerate

    // ---------------- arbitration ----------------
    // The core cannot request in its ack cycle, which leaves that slot free
    // for a waiting host; on a true conflict the last loser wins.
    assign host_req   = ~reset & (state_q == S_MEM_REQ);
    assign core_req   = ~reset & core_cs & ~core_rst_q & ~core_ack_q;
    assign grant_core = core_req & (~host_req | ~last_core_q);
    assign grant_host = host_req & (~core_req | last_core_q);

    assign core_ack_d  = grant_core;
    assign last_core_d = grant_core ? 1'b1 : (grant_host ? 1'b0 : last_core_q);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_core) begin
            mem_en    = 1'b1;
            mem_we    = core_we ? core_wmask : '0;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (grant_host) begin
            mem_en    = 1'b1;
            mem_we    = (cmd_q == CMD_WR) ? {NBYTES{1'b1}} : '0;
            mem_addr  = addr_q;
            mem_wdata = data_q;
        end
    end

    // ---------------- host byte interface ----------------
    always_comb begin
        rx_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE, S_ADDR, S_DATA: rx_ready = 1'b1;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
                S_CSUM:                 rx_ready = 1'b1;
`endif
                default:                rx_ready = 1'b0;
            endcase
        end
    end

    assign tx_valid = ~reset & (state_q == S_RESP);
    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;
    assign tx_data  = tx_valid ? tx_byte : 8'h00;

    assign core_rst   = core_rst_q | reset;
    assign core_ack   = core_ack_q & ~reset;
    assign core_rdata = core_ack ? mem_rdata : '0;

    assign resp_last = (cmd_q == CMD_RD) ? CNT_W'(RD_LEN - 1) : '0;

`ifdef UART_MEM_BRIDGE_CHKSUM_EN
    always_comb begin
        rd_csum = 8'h00;
        for (int i = 0; i < NBYTES; i++) rd_csum = rd_csum ^ rd_byte[i];
    end
`endif

    always_comb begin
        tx_byte = ACK_BYTE;
        if (cmd_q == CMD_NAK) begin
            tx_byte = NAK_BYTE;
        end else if (cmd_q == CMD_RD) begin
            tx_byte = 8'h00;
            for (int i = 0; i < NBYTES; i++) begin
                if (int'(cnt_q) == i) tx_byte = rd_byte[i];
            end
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
            if (int'(cnt_q) == NBYTES) tx_byte = rd_csum;
`endif
        end
    end

    // ---------------- host FSM ----------------
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        core_rst_d = core_rst_q;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    cnt_d = '0;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
                    csum_d = 8'h00;
`endif
                    case (rx_data)
                        8'h57: begin cmd_d = CMD_WR; state_d = S_ADDR; end
                        8'h52: begin cmd_d = CMD_RD; state_d = S_ADDR; end
                        8'h47: begin core_rst_d = 1'b0; cmd_d = CMD_ACK; state_d = S_RESP; end
                        8'h48: begin core_rst_d = 1'b1; cmd_d = CMD_ACK; state_d = S_RESP; end
                        default: begin cmd_d = CMD_NAK; state_d = S_RESP; end
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    // Bits of the byte that fall at or above ADDR_W are dropped.
                    for (int b = 0; b < ADDR_W; b++) begin
                        if (b / 8 == int'(cnt_q)) addr_d[b] = rx_data[b % 8];
                    end
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (cnt_q == CNT_W'(ABYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = (cmd_q == CMD_WR) ? S_DATA : S_MEM_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (int'(cnt_q) == i) data_d[i*8 +: 8] = rx_data;
                    end
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        cnt_d = '0;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_MEM_REQ;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
            S_CSUM: begin
                if (rx_fire) begin
                    if (rx_data == csum_q) begin
                        state_d = S_MEM_REQ;
                    end else begin
                        cmd_d   = CMD_NAK;
                        cnt_d   = '0;
                        state_d = S_RESP;
                    end
                end
            end
`endif
            S_MEM_REQ: begin
                if (grant_host) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (cmd_q == CMD_RD) data_d = mem_rdata;
                cnt_d   = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (cnt_q == resp_last) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_ACK;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            core_rst_q  <= 1'b1;
            core_ack_q  <= 1'b0;
            last_core_q <= 1'b0;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            core_rst_q  <= core_rst_d;
            core_ack_q  <= core_ack_d;
            last_core_q <= last_core_d;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Testbench for uart_mem_bridge: directed host command vectors from a table,
// plus hand-written sequences for core contention, reset in the middle of a
// command and (when the macro is defined) the checksum option.
module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        core_rst;
    logic        core_cs = 1'b0;
    logic        core_we = 1'b0;
    logic [4:0]  core_addr = 5'd0;
    logic [31:0] core_wdata = 32'h0;
    logic [3:0]  core_wmask = 4'h0;
    logic [31:0] core_rdata;
    logic        core_ack;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    uart_mem_bridge dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .core_rst(core_rst), .core_cs(core_cs), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_wmask(core_wmask),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port SRAM, read-before-write, one-cycle read.
    logic [31:0] sram [32];
    initial for (int i = 0; i < 32; i++) sram[i] = 32'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            for (int l = 0; l < 4; l++)
                if (mem_we[l]) sram[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
            mem_rdata <= sram[mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    // Bus monitor: samples between the input-driving edge and the active edge.
    int          mem_cnt = 0;
    logic [3:0]  last_we = 4'h0;
    logic [4:0]  last_addr = 5'h0;
    logic [31:0] last_wdata = 32'h0;
    int          ack_cnt = 0;
    int          b2b_cnt = 0;
    int          bad_rd_cnt = 0;
    logic        ack_prev = 1'b0;
    int          last_lat = -1;

    always @(negedge clk) begin
        #2;
        if (mem_en) begin
            mem_cnt++;
            last_we = mem_we;
            last_addr = mem_addr;
            last_wdata = mem_wdata;
        end
        if (core_ack) begin
            ack_cnt++;
            if (ack_prev) b2b_cnt++;
            if (core_rdata !== 32'h12345678) bad_rd_cnt++;
        end
        ack_prev = core_ack;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          nrx;
        logic [63:0] rx;      // bytes in send order, first byte most significant
        int          ntx;
        logic [63:0] tx;
        int          nmem;    // expected mem_en cycles, -1 = not checked
        logic [3:0]  we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        crst;
        logic        rnd;     // randomise tx_ready
        logic        autocs;  // append checksum bytes when the option is built in
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, int nrx, logic [63:0] rx, int ntx, logic [63:0] tx,
                                int nmem, logic [3:0] we, logic [4:0] addr, logic [31:0] wd,
                                logic crst, logic rnd, logic autocs);
        vec_t v;
        v.name = name; v.nrx = nrx; v.rx = rx; v.ntx = ntx; v.tx = tx;
        v.nmem = nmem; v.we = we; v.addr = addr; v.wd = wd;
        v.crst = crst; v.rnd = rnd; v.autocs = autocs;
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv(input string name, input logic [7:0] tq[$], input logic rnd);
        int got = 0;
        int cyc = 0;
        int lat = -1;
        logic hold = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < tq.size() && cyc < 300) begin
            if (tx_valid) begin
                if (lat < 0) lat = cyc;
                if (hold) check($sformatf("%s_hold%0d", name, got), {56'd0, tx_data}, {56'd0, held});
                tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tx_ready) begin
                    check($sformatf("%s_tx%0d", name, got), {56'd0, tx_data}, {56'd0, tq[got]});
                    got++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = tx_data;
                end
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b0;
        check($sformatf("%s_txcount", name), 64'(got), 64'(tq.size()));
        @(negedge clk);
        @(negedge clk);
        check($sformatf("%s_no_extra_tx", name), {63'd0, tx_valid}, 64'd0);
        check($sformatf("%s_idle", name), {63'd0, rx_ready}, 64'd1);
        last_lat = lat;
    endtask

    task automatic apply(input vec_t v);
        logic [7:0] bq[$];
        logic [7:0] tq[$];
        int m0;
        for (int i = 0; i < v.nrx; i++) bq.push_back(v.rx[(v.nrx-1-i)*8 +: 8]);
        for (int i = 0; i < v.ntx; i++) tq.push_back(v.tx[(v.ntx-1-i)*8 +: 8]);
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
        if (v.autocs) begin
            logic [7:0] cs = 8'h00;
            if (bq[0] == 8'h57) begin
                for (int i = 1; i < bq.size(); i++) cs ^= bq[i];
                bq.push_back(cs);
            end else if (bq[0] == 8'h52) begin
                foreach (tq[i]) cs ^= tq[i];
                tq.push_back(cs);
            end
        end
`endif
        m0 = mem_cnt;
        foreach (bq[i]) send_byte(bq[i]);
        recv(v.name, tq, v.rnd);
        if (v.nmem >= 0) begin
            check({v.name, "_memcnt"}, 64'(mem_cnt - m0), 64'(v.nmem));
            if (v.nmem == 1) begin
                check({v.name, "_we"}, {60'd0, last_we}, {60'd0, v.we});
                check({v.name, "_addr"}, {59'd0, last_addr}, {59'd0, v.addr});
                if (v.we != 4'h0)
                    check({v.name, "_wdata"}, {32'd0, last_wdata}, {32'd0, v.wd});
            end
        end
        check({v.name, "_core_rst"}, {63'd0, core_rst}, {63'd0, v.crst});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, b0, r0, m0, t;

        vecs.push_back(mk("wr3",   6, 48'h57_03_78_56_34_12, 1, 8'h06,                1, 4'hF, 5'd3,  32'h12345678, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("rd3",   2, 16'h52_03,             4, 32'h78_56_34_12,      1, 4'h0, 5'd3,  32'h0,        1'b1, 1'b1, 1'b1));
        vecs.push_back(mk("bad99", 1, 8'h99,                 1, 8'h15,                0, 4'h0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("wr31",  6, 48'h57_1F_EF_BE_AD_DE, 1, 8'h06,                1, 4'hF, 5'd31, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("rd31",  2, 16'h52_1F,             4, 32'hEF_BE_AD_DE,      1, 4'h0, 5'd31, 32'h0,        1'b1, 1'b1, 1'b1));
        vecs.push_back(mk("wrhi",  6, 48'h57_E5_11_22_33_44, 1, 8'h06,                1, 4'hF, 5'd5,  32'h44332211, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("rd5",   2, 16'h52_25,             4, 32'h11_22_33_44,      1, 4'h0, 5'd5,  32'h0,        1'b1, 1'b1, 1'b1));
        vecs.push_back(mk("go",    1, 8'h47,                 1, 8'h06,                0, 4'h0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("halt",  1, 8'h48,                 1, 8'h06,                0, 4'h0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("bad00", 1, 8'h00,                 1, 8'h15,                0, 4'h0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1));

        // Reset values, sampled while reset is held.
        @(negedge clk);
        @(negedge clk);
        check("rst_core_rst",  {63'd0, core_rst}, 64'd1);
        check("rst_rx_ready",  {63'd0, rx_ready}, 64'd0);
        check("rst_tx_valid",  {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data",   {56'd0, tx_data},  64'd0);
        check("rst_core_ack",  {63'd0, core_ack}, 64'd0);
        check("rst_core_rdata",{32'd0, core_rdata}, 64'd0);
        check("rst_mem_en",    {63'd0, mem_en},   64'd0);
        check("rst_mem_we",    {60'd0, mem_we},   64'd0);
        check("rst_mem_addr",  {59'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_core_rst", {63'd0, core_rst}, 64'd1);
        check("post_rst_rx_ready", {63'd0, rx_ready}, 64'd1);

        foreach (vecs[i]) apply(vecs[i]);

        // Core alone: one access every second cycle.
        apply(mk("go2", 1, 8'h47, 1, 8'h06, 0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1));
        a0 = ack_cnt; b0 = b2b_cnt; r0 = bad_rd_cnt;
        core_addr = 5'd3; core_we = 1'b0; core_wmask = 4'h0;
        core_cs = 1'b1;
        repeat (10) @(negedge clk);
        core_cs = 1'b0;
        repeat (2) @(negedge clk);
        check("core_alone_acks", 64'(ack_cnt - a0), 64'd5);

        // Host read while the core keeps requesting.
        core_cs = 1'b1;
        apply(mk("rd3_cont", 2, 16'h52_03, 4, 32'h78_56_34_12, -1, 4'h0, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1));
        check("cont_host_latency_max", {63'd0, last_lat <= 4}, 64'd1);
        check("cont_host_latency_min", {63'd0, last_lat >= 2}, 64'd1);
        t = 0;
        while (!core_ack && t < 10) begin
            @(negedge clk);
            t++;
        end
        core_cs = 1'b0;
        repeat (2) @(negedge clk);
        check("cont_acks_min", {63'd0, (ack_cnt - a0) >= 7}, 64'd1);
        check("cont_no_b2b_ack", 64'(b2b_cnt - b0), 64'd0);
        check("cont_core_rdata", 64'(bad_rd_cnt - r0), 64'd0);

        // Core held in reset is never granted.
        apply(mk("halt2", 1, 8'h48, 1, 8'h06, 0, 4'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1));
        m0 = mem_cnt; a0 = ack_cnt;
        core_cs = 1'b1;
        repeat (4) @(negedge clk);
        core_cs = 1'b0;
        @(negedge clk);
        check("halted_core_no_mem", 64'(mem_cnt - m0), 64'd0);
        check("halted_core_no_ack", 64'(ack_cnt - a0), 64'd0);

        // Reset in the middle of a write discards it.
        m0 = mem_cnt;
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'hAA);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_no_mem", 64'(mem_cnt - m0), 64'd0);
        check("midrst_core_rst", {63'd0, core_rst}, 64'd1);
        check("midrst_idle", {63'd0, rx_ready}, 64'd1);
        apply(mk("midrst_rd3", 2, 16'h52_03, 4, 32'h78_56_34_12, 1, 4'h0, 5'd3, 32'h0, 1'b1, 1'b1, 1'b1));

`ifdef UART_MEM_BRIDGE_CHKSUM_EN
        apply(mk("cs_bad",  7, 56'h57_03_78_56_34_12_00, 1, 8'h15, 0, 4'h0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0));
        apply(mk("cs_good", 7, 56'h57_03_78_56_34_12_0B, 1, 8'h06, 1, 4'hF, 5'd3, 32'h12345678, 1'b1, 1'b0, 1'b0));
        apply(mk("cs_rd3",  2, 16'h52_03, 5, 40'h78_56_34_12_08, 1, 4'h0, 5'd3, 32'h0, 1'b1, 1'b1, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
